// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register.
// Holds the skid FSM state encodings, the default payload width and the stall counter width.
// Imported by the interface, the slot register and the top.
package pipe_pkg;

    localparam int WORD_W      = 16;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_TWO   = 2'b10
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle between an upstream stage, the skid register and the downstream stage.
// slave modport = skid register side; master modport = surrounding pipeline / bench side.
// Signals: in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream), flush, stall_cnt.
interface pipe_skid_reg_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = WORD_W
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   flush;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, stall_cnt
    );

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, stall_cnt
    );

endinterface

// File: rtl/pipe_slot.sv
// Purpose: WIDTH-bit storage slot with load enable and synchronous clear.
// Latency: loaded value visible one cycle after i_load; i_clr has priority over i_load.
// Backpressure: none; the owner decides when to load.
// Ports: clk, rst_n (async active-low, resets to RST_VAL), i_load, i_clr, i_d, o_q.
module pipe_slot #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else if (i_clr) begin
            r_q <= RST_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Purpose: two-entry skid register (main + skid slot) closing a valid/ready hop between pipeline stages.
// Latency: accepted word is on out_data the cycle after the accept edge; 1 word/cycle sustained.
// Backpressure: in_ready is a flop, low only when both slots are full; flush empties both slots.
// Ports: clk, rst (async active-low), bus (pipe_skid_reg_if.slave).
// Build option: PIPE_SKID_STALL_CNT_EN adds a saturating stall counter on stall_cnt (else tied to 0).
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH   = WORD_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    pipe_skid_reg_if.slave  bus
);

    skid_state_t      r_state;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_consume;
    logic             w_main_load;
    logic             w_skid_load;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_consume = r_out_valid & bus.out_ready;

    // Main slot loads on the first word into an empty register, on a pass-through
    // (accept with consume) in ONE, and when the skid word is promoted in TWO.
    assign w_main_load = ((r_state == SKID_EMPTY) && w_accept)
                       | ((r_state == SKID_ONE)   && w_accept && w_consume)
                       | ((r_state == SKID_TWO)   && w_consume);
    assign w_skid_load = (r_state == SKID_ONE) && w_accept && !w_consume;
    assign w_main_d    = (r_state == SKID_TWO) ? w_skid_q : bus.in_data;

    pipe_slot #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
        .clk    (clk),
        .rst_n  (rst),
        .i_load (w_main_load),
        .i_clr  (bus.flush),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    pipe_slot #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_skid (
        .clk    (clk),
        .rst_n  (rst),
        .i_load (w_skid_load),
        .i_clr  (bus.flush),
        .i_d    (bus.in_data),
        .o_q    (w_skid_q)
    );

    // Occupancy FSM; in_ready/out_valid are registered copies of the next state
    // so neither depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                SKID_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= SKID_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (w_accept && !w_consume) begin
                        r_state    <= SKID_TWO;
                        r_in_ready <= 1'b0;
                    end else if (!w_accept && w_consume) begin
                        r_state     <= SKID_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                SKID_TWO: begin
                    if (w_consume) begin
                        r_state    <= SKID_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= SKID_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = w_main_q;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Counts cycles where a word is held by downstream; saturates, survives flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Downstream (capture) end of the inter-stage valid/ready handshake in the pipelined WISC core.
- Replaces a bare bank of flip-flops between stages with a two-entry skid register: a main slot plus a skid slot.
- Supports full throughput, backpressure with a registered in_ready, and a synchronous flush for branch mispredicts.
- Sits between stages, e.g. IF/ID and ID/EX.

Parameters:
- WIDTH, 16: payload width in bits (instruction or datapath word).
- RST_VAL, 0: value out_data and both slots take on reset and flush.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  upstream has a word on in_data.
- in_ready  out  1  block can accept a word; driven from a flop (no combinational path from out_ready).
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  downstream consumes the word this cycle.
- out_data  out  WIDTH  payload; always the main slot.
- flush  in  1  synchronous kill of all buffered words.
- stall_cnt  out  16  backpressure statistic (see Optional Feature).

Behaviour:
- Transfer rules: accept = in_valid & in_ready; consume = out_valid & out_ready. Data is captured only on accept.
- Reset (rst=0, asynchronous):
  - state EMPTY, out_valid=0, in_ready=1, out_data=RST_VAL, skid slot=RST_VAL, stall_cnt=0.
  - Reset mid-transfer drops all words.
- States: EMPTY (no word), ONE (main valid), TWO (main+skid valid). out_valid=(state!=EMPTY). in_ready=(state!=TWO), registered.
- Transitions (no flush):
  - EMPTY: accept -> ONE, main<=in_data; else stay.
  - ONE:
    - accept & consume -> ONE, main<=in_data.
    - accept & !consume -> TWO, skid<=in_data.
    - !accept & consume -> EMPTY.
    - neither -> stay.
  - TWO (in_ready=0, no accept possible): consume -> ONE, main<=skid; else stay.
- Latency: an accepted word appears on out_data the cycle after the accept edge. Sustained throughput is 1 word/cycle with out_ready held high.
- Ordering: strict FIFO; the skid word is never presented before the main word.
- Flush:
  - Next state EMPTY, in_ready=1, both slots <=RST_VAL.
  - A word offered in the flush cycle is dropped.
  - Flush wins over simultaneous accept and consume; downstream must ignore out_valid in the flush cycle (pipeline convention).
- Simultaneous accept & consume in ONE gives no net occupancy change.
- Holding: out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Violation: in_valid while in_ready=0 is legal and ignored. Upstream must hold in_data and in_valid until accept.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - 16-bit counter increments each cycle with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: no counter flops; stall_cnt tied to 16'h0000. Port list is unchanged.

Decomposition:
- Shared package pipe_pkg holds:
  - 2-bit state encodings SKID_EMPTY=2'b00, SKID_ONE=2'b01, SKID_TWO=2'b10.
  - Default WORD_W=16 used for WIDTH.
  - STALL_CNT_W=16.
- Sub-module pipe_slot: WIDTH-wide register with load enable, synchronous clear (flush) and async active-low reset to RST_VAL. It is instantiated twice, for main and skid.

Test Plan:
- Reset: hold rst=0 with in_valid=1, in_data=16'hABCD -> out_valid=0, in_ready=1, out_data=16'h0000. Release rst -> word 16'hABCD is accepted in the first cycle and appears the next cycle.
- Streaming: out_ready=1, send 16'h0001..16'h0008 back-to-back -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready never drops.
- Backpressure:
  - Send 16'h0011, 16'h0022, 16'h0033 with out_ready=0 -> after two accepts in_ready=0 and 16'h0033 is held off upstream.
  - Raise out_ready -> 16'h0011, 16'h0022, 16'h0033 appear in order, with no loss or duplication.
- Flush in TWO with in_valid=1, in_data=16'h00FF -> next cycle out_valid=0, in_ready=1, 16'h00FF never appears. The following word passes normally.
- Random valid/ready (10k cycles, random stalls both sides) -> scoreboard matches in order. in_ready equals a registered function of state; no combinational dependence on out_ready.
- With PIPE_SKID_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and stays there. Without the macro -> stall_cnt=0 throughout.
